piso_framer: RTL

PISO_FRAMER -- requirements
Module: piso_framer

---
 rtl/piso_framer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/piso_framer.sv
// piso_framer: parallel-in serial-out framer.
// Accepts a WIDTH-bit word when load_valid and load_ready are both high.
// It sends a start bit (0), the data bits MSB first, an optional parity
// bit and a stop bit (1). All outputs are registered.
// Optional feature macro: PISO_FRAMER_PARITY_EN adds one even-parity bit.
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst        - synchronous active-high reset
//   din        - parallel word to serialize
//   load_valid - din holds a word to accept
//   load_ready - the block accepts a word this cycle
//   o          - registered serial line, idles high
//   bit_valid  - high while o carries a data bit
//   busy       - high while a frame is in progress
//   done       - single-cycle pulse during the stop bit
module piso_framer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             o,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PISO_FRAMER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             o_q, o_d;
    logic             bv_q, busy_q, done_q, rdy_q;
    logic             xfer;
`ifdef PISO_FRAMER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign xfer = load_valid & rdy_q;

    // Outputs are computed from the next state so that the registered
    // copy lines up with the state it describes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        o_d     = 1'b1;
`ifdef PISO_FRAMER_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE, STOP: begin
                state_d = IDLE;
                if (xfer) begin
                    state_d = START;
                    sh_d    = din;
                    o_d     = 1'b0;
`ifdef PISO_FRAMER_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            START: begin
                state_d = DATA;
                o_d     = sh_q[WIDTH-1];
                sh_d    = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST) begin
`ifdef PISO_FRAMER_PARITY_EN
                    state_d = PARITY;
                    o_d     = par_q;
`else
                    state_d = STOP;
`endif
                end else begin
                    o_d   = sh_q[WIDTH-1];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef PISO_FRAMER_PARITY_EN
            PARITY: begin
                state_d = STOP;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            o_q     <= 1'b1;
            bv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef PISO_FRAMER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            o_q     <= o_d;
            bv_q    <= (state_d == DATA);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == STOP);
            rdy_q   <= (state_d == IDLE) || (state_d == STOP);
`ifdef PISO_FRAMER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign load_ready = rdy_q;
    assign o          = o_q;
    assign bit_valid  = bv_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
